mem_cycle_sched: RTL and testbench

Core-memory cycle scheduler for the LVDC memory module. It shares one memory module between two requesters: the processor sequencer (CPU port) and the data-adapter input channel (IO port). It runs the destructive read/regenerate core cycle of select, read strobe, sense, write strobe and recovery, and generates and checks word parity. It sits between the processor/IO logic and the memory timing and buffer-register drive lines.

---
 rtl/mem_cycle_sched.sv | 110 +++++++++++
 tb/tb_mem_cycle_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_cycle_sched.sv
// mem_cycle_sched: arbitrates CPU/IO access to one core memory module and runs its read/regenerate cycle with odd parity
module mem_cycle_sched #(
  parameter int AW        = 13,
  parameter int DW        = 26,
  parameter int READ_CYC  = 2,
  parameter int WRITE_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          halt,
  input  logic          cpu_req,
  input  logic          io_req,
  input  logic          cpu_wr,
  input  logic          io_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [AW-1:0] io_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [DW-1:0] io_wdata,
  output logic          cpu_ack,
  output logic          io_ack,
  output logic [DW-1:0] rdata,
  output logic          perr,
  output logic          gnt_io,
  output logic          busy,
  output logic          mem_sel,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rstb,
  output logic          mem_wstb,
  input  logic [DW:0]   mem_di,
  output logic [DW:0]   mem_do
);
  typedef enum logic [2:0] {IDLE, SELECT, READ, SENSE, WRITE, RECOVER} state_t;
  localparam logic [2:0] RC = 3'(READ_CYC - 1);
  localparam logic [2:0] WC = 3'(WRITE_CYC - 1);
  state_t state;
  logic [2:0] cnt;
  logic wr, last_io, perr_r, pick_io;
  logic [DW-1:0] wdata;
  // on a tie the requester not served last wins
  assign pick_io = io_req & ~(cpu_req & last_io);
  // core cycle sequencer; every output is a register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      wr       <= 1'b0;
      wdata    <= '0;
      last_io  <= 1'b1;
      perr_r   <= 1'b0;
      cpu_ack  <= 1'b0;
      io_ack   <= 1'b0;
      rdata    <= '0;
      perr     <= 1'b0;
      gnt_io   <= 1'b0;
      busy     <= 1'b0;
      mem_sel  <= 1'b0;
      mem_addr <= '0;
      mem_rstb <= 1'b0;
      mem_wstb <= 1'b0;
      mem_do   <= '0;
    end else begin
      case (state)
        IDLE: if (!halt && (cpu_req || io_req)) begin
          state    <= SELECT;
          mem_sel  <= 1'b1;
          busy     <= 1'b1;
          gnt_io   <= pick_io;
          last_io  <= pick_io;
          mem_addr <= pick_io ? io_addr : cpu_addr;
          wr       <= pick_io ? io_wr : cpu_wr;
          wdata    <= pick_io ? io_wdata : cpu_wdata;
        end
        SELECT: begin
          state    <= READ;
          mem_rstb <= 1'b1;
          cnt      <= RC;
        end
        READ: if (cnt == 3'd0) begin
          state    <= SENSE;
          mem_rstb <= 1'b0;
        end else cnt <= cnt - 3'd1;
        SENSE: begin
          state    <= WRITE;
          mem_wstb <= 1'b1;
          cnt      <= WC;
          rdata    <= mem_di[DW-1:0];
          perr_r   <= ~^mem_di;
          mem_do   <= wr ? {~^wdata, wdata} : mem_di;
        end
        WRITE: if (cnt == 3'd0) begin
          state    <= RECOVER;
          mem_wstb <= 1'b0;
          mem_do   <= '0;
          cpu_ack  <= ~gnt_io;
          io_ack   <= gnt_io;
          perr     <= perr_r;
        end else cnt <= cnt - 3'd1;
        RECOVER: begin
          state   <= IDLE;
          mem_sel <= 1'b0;
          busy    <= 1'b0;
          cpu_ack <= 1'b0;
          io_ack  <= 1'b0;
          perr    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_cycle_sched.sv
// tb_mem_cycle_sched: directed bench with a cycle-offset model of the core memory cycle
module tb_mem_cycle_sched;
  localparam int AW = 13, DW = 26, RC = 2, WC = 2, T = RC + WC + 3;
  logic clk = 0, rst_n = 0, halt = 0, cpu_req = 0, io_req = 0, cpu_wr = 0, io_wr = 0;
  logic [AW-1:0] cpu_addr = '0, io_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, io_wdata = '0;
  logic [DW:0] mem_di = '0;
  logic cpu_ack, io_ack, perr, gnt_io, busy, mem_sel, mem_rstb, mem_wstb;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW:0] mem_do;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mem_cycle_sched #(.AW(AW), .DW(DW), .READ_CYC(RC), .WRITE_CYC(WC)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .cpu_req(cpu_req), .io_req(io_req),
    .cpu_wr(cpu_wr), .io_wr(io_wr), .cpu_addr(cpu_addr), .io_addr(io_addr),
    .cpu_wdata(cpu_wdata), .io_wdata(io_wdata), .cpu_ack(cpu_ack), .io_ack(io_ack),
    .rdata(rdata), .perr(perr), .gnt_io(gnt_io), .busy(busy), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_rstb(mem_rstb), .mem_wstb(mem_wstb),
    .mem_di(mem_di), .mem_do(mem_do)
  );

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, a, e);
    end
  endtask

  // model: c = cycle number since the grant edge (0 = idle)
  int c = 0;
  logic m_io = 0, m_last_io = 1, m_wr = 0, m_perr = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0, m_rdata = '0;
  logic [DW:0] m_regen = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c = 0; m_io = 0; m_last_io = 1; m_wr = 0; m_perr = 0;
      m_addr = '0; m_wd = '0; m_rdata = '0; m_regen = '0;
    end else if (c == 0) begin
      if (!halt && (cpu_req || io_req)) begin
        if (cpu_req && io_req) m_io = !m_last_io;
        else m_io = io_req;
        m_last_io = m_io;
        m_addr = m_io ? io_addr : cpu_addr;
        m_wr = m_io ? io_wr : cpu_wr;
        m_wd = m_io ? io_wdata : cpu_wdata;
        c = 1;
      end
    end else begin
      if (c == RC + 2) begin
        m_rdata = mem_di[DW-1:0];
        m_regen = mem_di;
        m_perr = (^mem_di) == 1'b0;
      end
      c = (c == T) ? 0 : c + 1;
    end
  end

  always @(negedge clk) begin
    logic busy_e, r_e, w_e, ack_e;
    logic [DW:0] do_e;
    if (rst_n) begin
      busy_e = c != 0;
      r_e = c >= 2 && c <= RC + 1;
      w_e = c >= RC + 3 && c <= RC + WC + 2;
      ack_e = c == T;
      do_e = w_e ? (m_wr ? {~^m_wd, m_wd} : m_regen) : '0;
      chk("busy", busy, busy_e);
      chk("mem_sel", mem_sel, busy_e);
      chk("mem_rstb", mem_rstb, r_e);
      chk("mem_wstb", mem_wstb, w_e);
      chk("mem_do", mem_do, do_e);
      chk("cpu_ack", cpu_ack, ack_e && !m_io);
      chk("io_ack", io_ack, ack_e && m_io);
      chk("perr", perr, ack_e && m_perr);
      chk("gnt_io", gnt_io, m_io);
      chk("mem_addr", mem_addr, m_addr);
      chk("rdata", rdata, m_rdata);
    end
  end

  task automatic wait_ack(output int n, output logic cs, output logic ios, output logic pe,
                          output logic gi, output logic [DW:0] dw, output logic [7:0] rm,
                          output logic [7:0] wm);
    n = 0; cs = 0; ios = 0; pe = 0; gi = 0; dw = '0; rm = '0; wm = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (n < 8) begin
        rm[n[2:0]] = mem_rstb;
        wm[n[2:0]] = mem_wstb;
      end
      if (mem_wstb) dw = mem_do;
      if (cpu_ack || io_ack) begin
        cs = cpu_ack; ios = io_ack; pe = perr; gi = gnt_io;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL ack_timeout: no ACK within 40 cycles, required one");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic cs, ios, pe, gi;
    logic [DW:0] dw;
    logic [7:0] rm, wm;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_gnt", gnt_io, 0);
    // CPU read, odd-parity word
    cpu_addr = 13'h0123; mem_di = 27'h0000001; cpu_req = 1;
    wait_ack(n, cs, ios, pe, gi, dw, rm, wm);
    chk("s1_lat", n, 7); chk("s1_cpu_ack", cs, 1); chk("s1_io_ack", ios, 0);
    chk("s1_rstb", rm, 8'b00001100); chk("s1_wstb", wm, 8'b01100000);
    chk("s1_do", dw, 27'h0000001); chk("s1_rdata", rdata, 26'h0000001);
    chk("s1_perr", pe, 0); chk("s1_addr", mem_addr, 13'h0123);
    cpu_req = 0;
    @(negedge clk);
    // IO write, 25 ones -> parity bit 0
    io_addr = 13'h1ABC; io_wr = 1; io_wdata = 26'h3FFFFFE; io_req = 1;
    wait_ack(n, cs, ios, pe, gi, dw, rm, wm);
    chk("s2_lat", n, 7); chk("s2_io_ack", ios, 1); chk("s2_cpu_ack", cs, 0);
    chk("s2_do", dw, 27'h3FFFFFE); chk("s2_gnt", gi, 1); chk("s2_addr", mem_addr, 13'h1ABC);
    io_req = 0; io_wr = 0;
    @(negedge clk);
    // CPU write of zero -> parity bit 1
    cpu_addr = 13'h0042; cpu_wr = 1; cpu_wdata = 26'h0; cpu_req = 1;
    wait_ack(n, cs, ios, pe, gi, dw, rm, wm);
    chk("s3_do", dw, 27'h4000000); chk("s3_cpu_ack", cs, 1); chk("s3_rdata_old", rdata, 26'h0000001);
    cpu_req = 0; cpu_wr = 0;
    @(negedge clk);
    // even-parity read flags PERR and regenerates the word unchanged
    mem_di = 27'h0000000; cpu_req = 1;
    wait_ack(n, cs, ios, pe, gi, dw, rm, wm);
    chk("s4_perr", pe, 1); chk("s4_do", dw, 27'h0); chk("s4_rdata", rdata, 26'h0);
    cpu_req = 0;
    @(negedge clk);
    chk("s4_perr_after", perr, 0);
    // tie from reset: CPU, IO, CPU, 8 cycles apart
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    mem_di = 27'h0000001; cpu_req = 1; io_req = 1;
    wait_ack(n, cs, ios, pe, gi, dw, rm, wm);
    chk("s5_lat0", n, 7); chk("s5_gnt0", gi, 0); chk("s5_ack0", cs, 1);
    wait_ack(n, cs, ios, pe, gi, dw, rm, wm);
    chk("s5_lat1", n, 8); chk("s5_gnt1", gi, 1); chk("s5_ack1", ios, 1);
    wait_ack(n, cs, ios, pe, gi, dw, rm, wm);
    chk("s5_lat2", n, 8); chk("s5_gnt2", gi, 0); chk("s5_ack2", cs, 1);
    cpu_req = 0; io_req = 0;
    @(negedge clk);
    // HALT during READ with IO pending
    cpu_req = 1;
    repeat (3) @(negedge clk);
    halt = 1; io_req = 1;
    wait_ack(n, cs, ios, pe, gi, dw, rm, wm);
    chk("s6_lat", n, 4); chk("s6_cpu_ack", cs, 1);
    cpu_req = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("s6_halt_idle", busy, 0);
    end
    halt = 0;
    @(negedge clk);
    chk("s6_regrant_busy", busy, 1); chk("s6_regrant_io", gnt_io, 1);
    wait_ack(n, cs, ios, pe, gi, dw, rm, wm);
    chk("s6_io_lat", n, 6); chk("s6_io_ack", ios, 1);
    io_req = 0;
    @(negedge clk);
    // async reset during WRITE
    cpu_req = 1;
    repeat (5) @(negedge clk);
    chk("s7_in_write", mem_wstb, 1);
    #1 rst_n = 0;
    #1;
    chk("s7_wstb_drop", mem_wstb, 0); chk("s7_sel_drop", mem_sel, 0); chk("s7_busy_drop", busy, 0);
    cpu_req = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("s7_no_ack", cpu_ack | io_ack, 0);
    end
    cpu_req = 1; io_req = 1;
    wait_ack(n, cs, ios, pe, gi, dw, rm, wm);
    chk("s7_tie_lat", n, 7); chk("s7_tie_cpu", cs, 1); chk("s7_tie_gnt", gi, 0);
    cpu_req = 0; io_req = 0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
